// File: rtl/instr_loader.sv
// instr_loader: packs a byte stream into 21-bit words and writes them to instruction memory.
// Optional checksum gate on CPU release: define INSTR_LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int WORD_COUNT = 256
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        WR_EN,
  output logic [7:0]  WR_ADDR,
  output logic [20:0] WR_DATA,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERROR
);

  typedef enum logic [2:0] {
    S_IDLE, S_B0, S_B1, S_B2, S_WRITE, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [7:0] LAST = 8'(WORD_COUNT - 1);

  state_t     state;
  state_t     nxt;
  logic [4:0] hi;
  logic [7:0] mid;
  logic       restart;

  assign restart = START &&
    (state == S_IDLE || state == S_DONE || state == S_ERR);

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       sum_ok;
  assign sum_ok = (8'(csum + BYTE_IN) == 8'd0);
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; byte states wait for BYTE_VALID
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (START) nxt = S_B0;
      S_B0:    if (BYTE_VALID) nxt = S_B1;
      S_B1:    if (BYTE_VALID) nxt = S_B2;
      S_B2:    if (BYTE_VALID) nxt = S_WRITE;
      S_WRITE: begin
        if (WR_ADDR == LAST) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          nxt = S_CHECK;
`else
          nxt = S_DONE;
`endif
        end else begin
          nxt = S_B0;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CHECK: if (BYTE_VALID) nxt = sum_ok ? S_DONE : S_ERR;
`endif
      default: nxt = S_IDLE;
    endcase
  end

  // Word assembly and address counter; WR_DATA only changes on entry to WRITE
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi      <= '0;
      mid     <= '0;
      WR_DATA <= '0;
      WR_ADDR <= '0;
    end else begin
      if (restart) WR_ADDR <= '0;
      if (state == S_B0 && BYTE_VALID) hi <= BYTE_IN[4:0];
      if (state == S_B1 && BYTE_VALID) mid <= BYTE_IN;
      if (state == S_B2 && BYTE_VALID) WR_DATA <= {hi, mid, BYTE_IN};
      if (state == S_WRITE && WR_ADDR != LAST) WR_ADDR <= WR_ADDR + 8'd1;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // Running byte sum over all data bytes of the current image
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      csum <= '0;
    end else if (restart) begin
      csum <= '0;
    end else if (BYTE_VALID &&
                 (state == S_B0 || state == S_B1 || state == S_B2)) begin
      csum <= csum + BYTE_IN;
    end
  end

  assign ERROR = (state == S_ERR);
`else
  assign ERROR = 1'b0;
`endif

  assign BYTE_READY = (state == S_B0) || (state == S_B1) ||
                      (state == S_B2) || (state == S_CHECK);
  assign WR_EN      = (state == S_WRITE);
  assign DONE       = (state == S_DONE);
  assign CPU_HOLD   = (state != S_DONE);

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed bench for instr_loader with a write-queue model.
// Checksum scenarios run when INSTR_LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        WR_EN;
  logic [7:0]  WR_ADDR;
  logic [20:0] WR_DATA;
  logic        CPU_HOLD;
  logic        DONE;
  logic        ERROR;

  instr_loader #(.WORD_COUNT(2)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  a;
    logic [20:0] d;
  } wr_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  wr_t         exp_q[$];
  logic [20:0] log_d[$];
  logic [7:0]  log_a[$];
  logic [7:0]  prog[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] pack(input logic [7:0] b0,
                                       input logic [7:0] b1,
                                       input logic [7:0] b2);
    return {b0[4:0], b1, b2};
  endfunction

  // Compare process: every write must match the next expected one
  always @(negedge CLK) begin
    if (!RST) begin
      chk("hold_vs_done", {31'd0, CPU_HOLD}, {31'd0, !DONE});
      if (WR_EN) begin
        wr_cnt++;
        log_a.push_back(WR_ADDR);
        log_d.push_back(WR_DATA);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'd0, WR_EN}, 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, WR_ADDR}, {24'd0, e.a});
          chk("wr_data", {11'd0, WR_DATA}, {11'd0, e.d});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reset();
    chk("rst_ready", {31'd0, BYTE_READY}, 32'd0);
    chk("rst_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("rst_addr", {24'd0, WR_ADDR}, 32'd0);
    chk("rst_data", {11'd0, WR_DATA}, 32'd0);
    chk("rst_hold", {31'd0, CPU_HOLD}, 32'd1);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_error", {31'd0, ERROR}, 32'd0);
  endtask

  task automatic do_start();
    START = 1'b1;
    tick(1);
    START = 1'b0;
    chk("ready_after_start", {31'd0, BYTE_READY}, 32'd1);
    chk("done_after_start", {31'd0, DONE}, 32'd0);
    chk("hold_after_start", {31'd0, CPU_HOLD}, 32'd1);
    chk("error_after_start", {31'd0, ERROR}, 32'd0);
  endtask

  // Present one byte and return at the negedge after it was taken
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    BYTE_IN    = b;
    BYTE_VALID = 1'b1;
    while (!BYTE_READY && n < 50) begin
      tick(1);
      n++;
    end
    if (!BYTE_READY) chk("send_timeout", {31'd0, BYTE_READY}, 32'd1);
    tick(1);
    BYTE_VALID = 1'b0;
  endtask

  task automatic load(input int maxgap, input bit good, input bit inject);
    int         c0;
    logic [7:0] s;
    s = 8'd0;
    for (int w = 0; w < 2; w++)
      exp_q.push_back('{8'(w), pack(prog[3*w], prog[3*w+1], prog[3*w+2])});
    for (int i = 0; i < 6; i++) s = s + prog[i];
    c0 = wr_cnt;
    log_a.delete();
    log_d.delete();
    for (int i = 0; i < 6; i++) begin
      send(prog[i]);
      if (inject && i == 0) begin
        START = 1'b1;
        tick(1);
        START = 1'b0;
        chk("start_ignored_ready", {31'd0, BYTE_READY}, 32'd1);
      end
      if (maxgap > 0 && i < 5) tick($urandom_range(0, maxgap));
    end
    chk("last_wr_en", {31'd0, WR_EN}, 32'd1);
    chk("last_wr_addr", {24'd0, WR_ADDR}, 32'd1);
    tick(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk("check_ready", {31'd0, BYTE_READY}, 32'd1);
    chk("check_not_done", {31'd0, DONE}, 32'd0);
    send(good ? 8'(8'd0 - s) : 8'(8'd1 - s));
    chk("end_done", {31'd0, DONE}, {31'd0, good});
    chk("end_error", {31'd0, ERROR}, {31'd0, !good});
    chk("end_hold", {31'd0, CPU_HOLD}, {31'd0, !good});
`else
    chk("end_done", {31'd0, DONE}, 32'd1);
    chk("end_hold", {31'd0, CPU_HOLD}, 32'd0);
    chk("end_error", {31'd0, ERROR}, 32'd0);
`endif
    chk("write_count", wr_cnt - c0, 32'd2);
    chk("model_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int c0;
    RST        = 1'b1;
    START      = 1'b0;
    BYTE_IN    = 8'h00;
    BYTE_VALID = 1'b0;
    tick(2);
    chk_reset();
    RST = 1'b0;
    tick(1);
    chk_reset();

    // Basic gapless load
    prog = '{8'h1F, 8'hAB, 8'hCD, 8'h00, 8'h12, 8'h34};
    do_start();
    load(0, 1'b1, 1'b0);
    chk("lit_w0", {11'd0, log_d[0]}, 32'h1FABCD);
    chk("lit_w1", {11'd0, log_d[1]}, 32'h001234);
    chk("lit_a1", {24'd0, log_a[1]}, 32'd1);

    // START from DONE; top bits of the first byte are dropped
    prog = '{8'hE5, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    do_start();
    load(0, 1'b1, 1'b0);
    chk("lit_e5", {11'd0, log_d[0]}, 32'h050000);
    chk("lit_aa", {11'd0, log_d[1]}, 32'h0ABBCC);

    // Gapped stream
    prog = '{8'h1F, 8'hAB, 8'hCD, 8'h00, 8'h12, 8'h34};
    for (int r = 0; r < 3; r++) begin
      do_start();
      load(3, 1'b1, 1'b0);
      chk("gap_w0", {11'd0, log_d[0]}, 32'h1FABCD);
    end

    // Reset mid-load drops the partial word
    do_start();
    c0 = wr_cnt;
    exp_q.push_back('{8'd0, pack(prog[0], prog[1], prog[2])});
    for (int i = 0; i < 5; i++) send(prog[i]);
    RST = 1'b1;
    tick(1);
    chk_reset();
    tick(2);
    chk("rst_write_count", wr_cnt - c0, 32'd1);
    RST = 1'b0;
    tick(1);
    do_start();
    load(0, 1'b1, 1'b0);
    chk("reload_a0", {24'd0, log_a[0]}, 32'd0);

    // START during B1 is ignored
    prog = '{8'h03, 8'h44, 8'h55, 8'h1E, 8'h66, 8'h77};
    do_start();
    load(1, 1'b1, 1'b1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    prog = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00};
    do_start();
    load(0, 1'b1, 1'b0);
    chk("lit_010203", {11'd0, log_d[0]}, 32'h010203);
    do_start();
    load(0, 1'b0, 1'b0);
    tick(2);
    chk("err_sticky", {31'd0, ERROR}, 32'd1);
    do_start();
`endif

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writer side of the 21-bit instruction store: receives a program as a byte stream over a valid/ready handshake, packs every three bytes into one 21-bit instruction word, and writes the words to sequential addresses of a writable instruction memory (8-bit address, 21-bit data). It holds the CPU in reset while loading and releases it once the full image has been written, and optionally checked.

## Interface
- WORD_COUNT, 256: number of words per image, 1..256; the last address written is WORD_COUNT-1.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE and ERR.
- BYTE_IN  in  8  program byte.
- BYTE_VALID  in  1  BYTE_IN is valid.
- BYTE_READY  out  1  loader accepts a byte this cycle; a transfer occurs when BYTE_VALID && BYTE_READY.
- WR_EN  out  1  one-cycle memory write strobe.
- WR_ADDR  out  8  write address.
- WR_DATA  out  21  instruction word.
- CPU_HOLD  out  1  holds the CPU in reset.
- DONE  out  1  image loaded; level output.
- ERROR  out  1  checksum failure; level output.

## Operation
- States: IDLE, B0, B1, B2, WRITE, CHECK (only when the macro is defined), DONE, ERR.
- IDLE, DONE, ERR: START moves the FSM to B0, clears WR_ADDR and the checksum, and sets CPU_HOLD=1, DONE=0, ERROR=0.
- START in any other state is ignored.
- B0: the accepted byte's bits [4:0] become WR_DATA[20:16]; bits [7:5] are discarded. Next state is B1.
- B1: the accepted byte becomes WR_DATA[15:8]. Next state is B2.
- B2: the accepted byte becomes WR_DATA[7:0]. Next state is WRITE.
- BYTE_READY=1 only in B0, B1, B2 and CHECK. While BYTE_VALID=0 the FSM holds its state.
- WRITE: WR_EN=1 for exactly one cycle. WR_ADDR and WR_DATA are stable through that cycle.
  - If WR_ADDR==WORD_COUNT-1, the next state is CHECK, or DONE when the macro is not defined.
  - Otherwise WR_ADDR increments by 1 and the next state is B0.
- WR_ADDR never wraps within one load; it is cleared only by START or RST.
- WR_DATA holds its last value outside WRITE.
- DONE: CPU_HOLD=0, DONE=1. The state is sticky until START or RST.
- ERR: CPU_HOLD=1, ERROR=1. The state is sticky until START or RST.
- BYTE_VALID in IDLE, WRITE, DONE or ERR is not accepted. The byte stays pending upstream.

## Timing
- Reset values: state IDLE, BYTE_READY=0, WR_EN=0, WR_ADDR=0, WR_DATA=0, CPU_HOLD=1, DONE=0, ERROR=0, checksum=0.
- RST in mid-load aborts immediately. A partially assembled word is dropped and no WR_EN is issued for it.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- START at edge n gives BYTE_READY=1 at cycle n+1.
- The third byte accepted at edge n gives WR_EN=1 during cycle n+1.
- Minimum throughput is 4 cycles per word: 3 byte cycles plus 1 write cycle.
- Last WRITE at cycle n gives DONE=1 and CPU_HOLD=0 at cycle n+1 without the macro. With the macro, the FSM enters CHECK at n+1 instead.
- START asserted with RST: RST wins.
- START in DONE: DONE falls and CPU_HOLD rises on the next edge.

## Configuration
- INSTR_LOADER_CHECKSUM_EN defined:
  - The loader keeps an 8-bit running sum, mod 256, of every accepted data byte.
  - After the last WRITE it enters CHECK and accepts one more byte.
  - If the sum plus that byte is 0 mod 256, the FSM enters DONE on the next edge; otherwise it enters ERR.
  - Memory contents are already written either way; only CPU release is gated.
- Not defined: the CHECK state, the checksum register and the ERR path are absent. ERROR is tied to 0 and the last WRITE goes straight to DONE.

## Test plan
- WORD_COUNT=2, no macro; START, then bytes 0x1F,0xAB,0xCD,0x00,0x12,0x34 with BYTE_VALID held high:
  - WR_EN at addr 0 with data 21'h1FABCD, then at addr 1 with data 21'h001234.
  - DONE=1 and CPU_HOLD=0 one cycle after the second write.
- First byte 0xE5 followed by 0x00,0x00: WR_DATA=21'h050000, showing bits [7:5] are discarded.
- BYTE_VALID toggling 1-0-1 with random gaps: same writes as the gapless run, no duplicate or lost bytes, WR_EN count equals WORD_COUNT.
- RST pulsed after the second byte of word 1: all outputs return to reset values, no WR_EN for word 1, and a fresh START reloads from addr 0.
- Macro defined, WORD_COUNT=1, bytes 0x01,0x02,0x03:
  - Checksum byte 0xFA gives DONE=1, ERROR=0.
  - Checksum byte 0xFB gives ERROR=1, CPU_HOLD=1, DONE=0.
  - START from ERR clears ERROR.
- START pulsed during B1: ignored; the load completes normally and WR_ADDR sequence is unchanged.
